// File: rtl/seq_pkg.sv
// Shared encodings and defaults for the serial sequence generator and detector.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StFin   = 2'd3
    } seq_state_e;

    localparam logic [3:0] PAT_0110     = 4'b0110;
    localparam logic       DEF_IDLE_BIT = 1'b1;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, shift-left register exposing its MSB.
module seq_piso_shift #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= data;
        end else if (shift) begin
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shift_q[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with idle gaps.
module sequence_generator
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W    = 4,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned GAP      = 1,
    parameter logic        IDLE_BIT = DEF_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             x,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    seq_state_e       state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             x_q, x_d, valid_q, valid_d, last_q, last_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             sr_load, sr_shift, sr_msb;
    logic [PAT_W-1:0] sr_data;

    // The shifter holds the bits still to come, so its MSB is always the next bit to drive.
    seq_piso_shift #(
        .WIDTH(PAT_W)
    ) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (sr_load),
        .shift(sr_shift),
        .data (sr_data),
        .msb  (sr_msb)
    );

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        pat_d    = pat_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_data  = {pat_q[PAT_W-2:0], 1'b0};
        x_d      = IDLE_BIT;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (abort) begin
            state_d = StIdle;
            bit_d   = '0;
            rep_d   = '0;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (repeat_cnt != '0) begin
                            pat_d   = pattern;
                            rep_d   = repeat_cnt;
                            bit_d   = '0;
                            sr_load = 1'b1;
                            sr_data = {pattern[PAT_W-2:0], 1'b0};
                            state_d = StShift;
                            x_d     = pattern[PAT_W-1];
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StFin;
                            done_d  = 1'b1;
                        end
                    end
                end
                StShift: begin
                    if (bit_q != BIT_W'(PAT_W - 1)) begin
                        sr_shift = 1'b1;
                        bit_d    = bit_q + BIT_W'(1);
                        x_d      = sr_msb;
                        valid_d  = 1'b1;
                        last_d   = (bit_q == BIT_W'(PAT_W - 2));
                        busy_d   = 1'b1;
                    end else begin
                        rep_d = rep_q - CNT_W'(1);
                        if (rep_q == CNT_W'(1)) begin
                            state_d = StFin;
                            done_d  = 1'b1;
                        end else if (GAP > 0) begin
                            state_d = StGap;
                            gap_d   = '0;
                            busy_d  = 1'b1;
                        end else begin
                            sr_load = 1'b1;
                            bit_d   = '0;
                            x_d     = pat_q[PAT_W-1];
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                StGap: begin
                    busy_d = 1'b1;
                    if (gap_q == 4'(GAP_LAST)) begin
                        state_d = StShift;
                        sr_load = 1'b1;
                        bit_d   = '0;
                        x_d     = pat_q[PAT_W-1];
                        valid_d = 1'b1;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
            x_q     <= IDLE_BIT;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            pat_q   <= pat_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: vector table, directed runs and random traffic vs. a queue model.
module tb_sequence_generator;

    typedef struct packed {
        logic x;
        logic valid;
        logic last;
        logic busy;
        logic done;
    } out_t;

    typedef struct {
        logic       start;
        logic       abort;
        logic [3:0] pat;
        logic [3:0] rc;
        out_t       exp;
    } vec_t;

    localparam out_t IDLE_O = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = 4'b0110;
    logic [3:0] repeat_cnt = 4'd1;
    logic       x1, v1, l1, b1, d1;
    logic       x0, v0, l0, b0, d0;

    int   checks = 0;
    int   errors = 0;
    out_t mq[2][$];
    out_t exp_o[2];
    logic fin_shown[2];

    always #5 clk = ~clk;

    sequence_generator #(.PAT_W(4), .CNT_W(4), .GAP(1), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .x(x1), .valid(v1), .last(l1), .busy(b1), .done(d1)
    );

    sequence_generator #(.PAT_W(4), .CNT_W(4), .GAP(0), .IDLE_BIT(1'b1)) dut_b2b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .x(x0), .valid(v0), .last(l0), .busy(b0), .done(d0)
    );

    function automatic out_t act(input int d);
        return (d == 0) ? out_t'({x1, v1, l1, b1, d1}) : out_t'({x0, v0, l0, b0, d0});
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // Model: an accepted request expands into the full list of per-cycle outputs.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int   gap;
            out_t o;
            gap = (d == 0) ? 1 : 0;
            o   = IDLE_O;
            if (!rst_n || abort) begin
                mq[d].delete();
            end else if (mq[d].size() != 0) begin
                o = mq[d].pop_front();
            end else if (!fin_shown[d] && start) begin
                for (int r = 0; r < int'(repeat_cnt); r++) begin
                    for (int i = 0; i < 4; i++)
                        mq[d].push_back({pattern[3-i], 1'b1, (i == 3), 1'b1, 1'b0});
                    if (r < int'(repeat_cnt) - 1)
                        for (int g = 0; g < gap; g++) mq[d].push_back(5'b10010);
                end
                mq[d].push_back(5'b10001);
                o = mq[d].pop_front();
            end
            fin_shown[d] = o.done;
            exp_o[d]     = o;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_gap1", 32'(act(0)), 32'(exp_o[0]));
        chk("model_gap0", 32'(act(1)), 32'(exp_o[1]));
    endtask

    // Launch one request, optionally poke a second start mid-run, and tally the run.
    task automatic count_run(input int n, input logic [3:0] pat, input logic [3:0] rc,
                             input int mid_at, output int busy_n[2], output int done_n[2],
                             output logic [63:0] xs[2], output logic [63:0] ls[2]);
        busy_n = '{0, 0};
        done_n = '{0, 0};
        xs     = '{64'd0, 64'd0};
        ls     = '{64'd0, 64'd0};
        pattern    = pat;
        repeat_cnt = rc;
        start      = 1'b1;
        for (int k = 0; k < n; k++) begin
            step();
            start = (k + 1 == mid_at);
            if (k + 1 == mid_at) begin
                pattern    = ~pat;
                repeat_cnt = 4'd1;
            end
            for (int d = 0; d < 2; d++) begin
                out_t o;
                o = act(d);
                if (o.busy) begin
                    busy_n[d]++;
                    xs[d] = {xs[d][62:0], o.x};
                    ls[d] = {ls[d][62:0], o.last};
                end
                if (o.done) done_n[d]++;
            end
        end
    endtask

    initial begin
        vec_t        tbl[13];
        int          bn[2], dn[2];
        logic [63:0] xs[2], ls[2];

        tbl[0]  = '{1'b1, 1'b0, 4'b0110, 4'd1, 5'b01010};
        tbl[1]  = '{1'b0, 1'b0, 4'b0110, 4'd1, 5'b11010};
        tbl[2]  = '{1'b0, 1'b0, 4'b0110, 4'd1, 5'b11010};
        tbl[3]  = '{1'b0, 1'b0, 4'b0110, 4'd1, 5'b01110};
        tbl[4]  = '{1'b0, 1'b0, 4'b0110, 4'd1, 5'b10001};
        tbl[5]  = '{1'b1, 1'b0, 4'b0110, 4'd1, 5'b10000};
        tbl[6]  = '{1'b1, 1'b0, 4'b0110, 4'd0, 5'b10001};
        tbl[7]  = '{1'b1, 1'b0, 4'b1001, 4'd2, 5'b10000};
        tbl[8]  = '{1'b1, 1'b1, 4'b1001, 4'd2, 5'b10000};
        tbl[9]  = '{1'b0, 1'b0, 4'b1001, 4'd2, 5'b10000};
        tbl[10] = '{1'b1, 1'b0, 4'b1001, 4'd1, 5'b11010};
        tbl[11] = '{1'b0, 1'b1, 4'b1001, 4'd1, 5'b10000};
        tbl[12] = '{1'b0, 1'b0, 4'b1001, 4'd1, 5'b10000};

        fin_shown = '{1'b0, 1'b0};
        exp_o     = '{IDLE_O, IDLE_O};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(act(0)), 32'(IDLE_O));
        rst_n = 1'b1;
        repeat (10) step();

        // Single pass, FIN ignoring start, zero count, abort beating start.
        for (int i = 0; i < 13; i++) begin
            start      = tbl[i].start;
            abort      = tbl[i].abort;
            pattern    = tbl[i].pat;
            repeat_cnt = tbl[i].rc;
            step();
            chk($sformatf("vec%0d", i), 32'(act(0)), 32'(tbl[i].exp));
        end
        abort = 1'b0;
        start = 1'b0;
        step();

        // Three repeats with a start poked mid-run.
        count_run(20, 4'b0110, 4'd3, 5, bn, dn, xs, ls);
        chk("rep3_busy_gap1", 32'(bn[0]), 32'd14);
        chk("rep3_busy_gap0", 32'(bn[1]), 32'd12);
        chk("rep3_done_gap1", 32'(dn[0]), 32'd1);
        chk("rep3_x_gap1", xs[0][31:0], 32'b01101011010110);

        // Back-to-back repetitions.
        count_run(12, 4'b0110, 4'd2, -1, bn, dn, xs, ls);
        chk("b2b_busy", 32'(bn[1]), 32'd8);
        chk("b2b_x", xs[1][31:0], 32'b01100110);
        chk("b2b_last", ls[1][31:0], 32'b00010001);
        chk("b2b_done", 32'(dn[1]), 32'd1);

        // Full repeat count must not wrap early.
        count_run(80, 4'b1011, 4'd15, -1, bn, dn, xs, ls);
        chk("full_busy_gap1", 32'(bn[0]), 32'd74);
        chk("full_busy_gap0", 32'(bn[1]), 32'd60);
        chk("full_done_gap1", 32'(dn[0]), 32'd1);

        // Abort during the second bit.
        pattern    = 4'b0110;
        repeat_cnt = 4'd2;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_x", 32'(x1), 32'd1);
        chk("abort_busy", 32'(b1), 32'd0);
        count_run(6, 4'b0110, 4'd0, -1, bn, dn, xs, ls);
        chk("abort_no_valid", 32'(bn[0]), 32'd0);

        // Asynchronous reset between edges mid-transfer.
        pattern    = 4'b0110;
        repeat_cnt = 4'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", 32'(x1), 32'd1);
        chk("arst_valid", 32'(v1), 32'd0);
        chk("arst_busy_b2b", 32'(b0), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            start      = ($urandom % 6) == 0;
            abort      = ($urandom % 40) == 0;
            pattern    = 4'($urandom);
            repeat_cnt = (($urandom % 10) == 0) ? 4'd15 : 4'($urandom % 5);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
